// File: rtl/spi_sram_responder_pkg.sv
// ============================================================================
// Module  : spi_sram_pkg
// Brief   : Command codes, FSM state and address-mode types for the SPI SRAM
//           responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10
  } mode_t;

  // The reserved encoding 2'b11 behaves as sequential mode.
  function automatic mode_t decode_mode(input logic [1:0] i_bits);
    case (i_bits)
      2'b00:   return MODE_BYTE;
      2'b10:   return MODE_PAGE;
      default: return MODE_SEQ;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sram_responder_if.sv
// ============================================================================
// Module  : spi_sram_if
// Brief   : SPI SRAM link pins; master = CPU side, slave = SRAM responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_sram_if;
  logic sram_ce;
  logic sclk;
  logic si;
  logic so;

  modport master (output sram_ce, output sclk, output si, input so);
  modport slave  (input sram_ce, input sclk, input si, output so);
endinterface

`default_nettype wire

// File: rtl/spi_sram_responder_sync_edge.sv
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-flop synchronizer with rise/fall detection on the last two
//           synchronized samples.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_sram_responder.sv
// ============================================================================
// Module  : spi_sram_responder
// Brief   : SPI mode-0 serial SRAM responder (READ/WRITE, 24-bit address),
//           oversampled in the clk domain. Optional mode register when
//           SPI_SRAM_MODE_REG_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int DEPTH       = 65536,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_sram_if.slave   spi
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [SYNC_STAGES-1:0] r_si_sync;
  logic                   w_ce;
  logic                   w_si;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  logic [4:0]             r_cnt;
  logic [6:0]             r_shift_in;
  logic [6:0]             r_shift_out;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_is_rd;
  logic                   r_so;

  logic                   r_wr_en;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [7:0]             r_rd_data;
  logic [7:0]             mem [DEPTH];

  logic [7:0]             w_byte;
  logic [7:0]             w_rd_byte;
  mode_t                  w_mode;

`ifdef SPI_SRAM_MODE_REG_EN
  mode_t                  r_mode;
  logic                   r_mr;
  assign w_mode    = r_mode;
  assign w_rd_byte = r_mr ? {r_mode, 6'b0} : r_rd_data;
`else
  assign w_mode    = MODE_SEQ;
  assign w_rd_byte = r_rd_data;
`endif

  spi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (spi.sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Same depth as the sclk path keeps si aligned with the detected rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ce_sync <= '1;
      r_si_sync <= '0;
    end else begin
      r_ce_sync <= {r_ce_sync[SYNC_STAGES-2:0], spi.sram_ce};
      r_si_sync <= {r_si_sync[SYNC_STAGES-2:0], spi.si};
    end
  end

  assign w_ce   = r_ce_sync[SYNC_STAGES-1];
  assign w_si   = r_si_sync[SYNC_STAGES-1];
  assign w_byte = {r_shift_in, w_si};
  assign spi.so = r_so;

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] i_a,
                                                    input mode_t             i_m);
    if (i_m == MODE_PAGE)
      return {i_a[ADDR_W-1:5], i_a[4:0] + 5'd1};
    else
      return i_a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (r_wr_en && reset)
      mem[r_wr_addr] <= r_wr_data;
    r_rd_data <= mem[r_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_so        <= 1'b0;
      r_cnt       <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_addr      <= '0;
      r_is_rd     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
`ifdef SPI_SRAM_MODE_REG_EN
      r_mode      <= MODE_SEQ;
      r_mr        <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_ce) begin
        // Deselect wins over any simultaneous sclk edge.
        r_state <= IDLE;
        r_so    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_so    <= 1'b0;
            r_cnt   <= '0;
            r_state <= CMD;
`ifdef SPI_SRAM_MODE_REG_EN
            r_mr    <= 1'b0;
`endif
          end

          CMD: begin
            r_so <= 1'b0;
            if (w_rise) begin
              r_shift_in <= w_byte[6:0];
              if (r_cnt == 5'd7) begin
                r_cnt <= '0;
                case (w_byte)
                  CMD_READ:  begin r_state <= ADDR; r_is_rd <= 1'b1; end
                  CMD_WRITE: begin r_state <= ADDR; r_is_rd <= 1'b0; end
`ifdef SPI_SRAM_MODE_REG_EN
                  CMD_RDMR:  begin r_state <= READ;  r_mr <= 1'b1; end
                  CMD_WRMR:  begin r_state <= WRITE; r_mr <= 1'b1; end
`else
                  CMD_RDMR, CMD_WRMR: r_state <= IGNORE;
`endif
                  default:   r_state <= IGNORE;
                endcase
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          ADDR: begin
            r_so <= 1'b0;
            if (w_rise) begin
              // Upper address bits simply shift out of the ADDR_W-bit register.
              r_addr <= {r_addr[ADDR_W-2:0], w_si};
              if (r_cnt == 5'd23) begin
                r_cnt   <= '0;
                r_state <= r_is_rd ? READ : WRITE;
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          READ: begin
            if (w_fall) begin
              if (r_cnt == 5'd0) begin
                r_so        <= w_rd_byte[7];
                r_shift_out <= w_rd_byte[6:0];
              end else begin
                r_so        <= r_shift_out[6];
                r_shift_out <= {r_shift_out[5:0], 1'b0};
              end
            end
            if (w_rise) begin
              if (r_cnt == 5'd7) begin
                r_cnt  <= '0;
                r_addr <= f_next_addr(r_addr, w_mode);
                if (w_mode == MODE_BYTE) begin
                  r_state <= IGNORE;
                  r_so    <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          WRITE: begin
            r_so <= 1'b0;
            if (w_rise) begin
              r_shift_in <= w_byte[6:0];
              if (r_cnt == 5'd7) begin
                r_cnt <= '0;
`ifdef SPI_SRAM_MODE_REG_EN
                if (r_mr) begin
                  r_mode  <= decode_mode(w_byte[7:6]);
                  r_state <= IGNORE;
                end else
`endif
                begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_data <= w_byte;
                  r_addr    <= f_next_addr(r_addr, w_mode);
                  if (w_mode == MODE_BYTE)
                    r_state <= IGNORE;
                end
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          IGNORE: begin
            r_so <= 1'b0;
          end

          default: begin
            r_so    <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
// ============================================================================
// Module  : tb_spi_sram_responder
// Brief   : Directed bench for spi_sram_responder with an SPI mode-0 master
//           BFM at clk = 8x sclk; mode-register cases under SPI_SRAM_MODE_REG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sram_responder;
  import spi_sram_pkg::*;

  localparam int HALF = 40;

  typedef logic [0:3][7:0] bytes4_t;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [23:0] addr;
    bit          has_addr;
    int          n;
    bytes4_t     d;
    bit          chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  int   so_hits  = 0;

  spi_sram_if spi ();

  spi_sram_responder #(
    .DEPTH       (65536),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (spi)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_en && spi.so !== 1'b0) so_hits++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi.si   = tx[i];
      #(HALF);
      spi.sclk = 1'b1;
      rx[i]    = spi.so;
      #(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input bit has_addr,
                      input int n, input bytes4_t tx, output bytes4_t rx);
    logic [7:0] b;
    rx = '0;
    @(negedge clk);
    spi.sram_ce = 1'b0;
    #(HALF);
    spi_byte(cmd, b);
    if (has_addr) begin
      spi_byte(addr[23:16], b);
      spi_byte(addr[15:8], b);
      spi_byte(addr[7:0], b);
    end
    for (int k = 0; k < n; k++) begin
      spi_byte(tx[k], b);
      rx[k] = b;
    end
    #(HALF);
    spi.sram_ce = 1'b1;
    #(4*HALF);
  endtask

  vec_t    vecs [8];
  bytes4_t rx;
  logic [7:0] b;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name:"wr_10",   cmd:CMD_WRITE, addr:24'h000010, has_addr:1, n:2, d:{8'hA5,8'h3C,8'h00,8'h00}, chk:0};
    vecs[1] = '{name:"rd_10",   cmd:CMD_READ,  addr:24'h000010, has_addr:1, n:2, d:{8'hA5,8'h3C,8'h00,8'h00}, chk:1};
    vecs[2] = '{name:"wr_ffff", cmd:CMD_WRITE, addr:24'h00FFFF, has_addr:1, n:2, d:{8'h11,8'h22,8'h00,8'h00}, chk:0};
    vecs[3] = '{name:"rd_ffff", cmd:CMD_READ,  addr:24'h00FFFF, has_addr:1, n:2, d:{8'h11,8'h22,8'h00,8'h00}, chk:1};
    vecs[4] = '{name:"rd_0",    cmd:CMD_READ,  addr:24'h000000, has_addr:1, n:1, d:{8'h22,8'h00,8'h00,8'h00}, chk:1};
    vecs[5] = '{name:"wr_20",   cmd:CMD_WRITE, addr:24'h000020, has_addr:1, n:1, d:{8'h77,8'h00,8'h00,8'h00}, chk:0};
    vecs[6] = '{name:"wr_hi40", cmd:CMD_WRITE, addr:24'h350040, has_addr:1, n:1, d:{8'h5A,8'h00,8'h00,8'h00}, chk:0};
    vecs[7] = '{name:"rd_40",   cmd:CMD_READ,  addr:24'h000040, has_addr:1, n:1, d:{8'h5A,8'h00,8'h00,8'h00}, chk:1};

    spi.sram_ce = 1'b1;
    spi.sclk    = 1'b0;
    spi.si      = 1'b0;
    reset       = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_so", {7'b0, spi.so}, 8'h00);
    check("reset_state", {5'b0, dut.r_state}, {5'b0, IDLE});
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      xfer(vecs[v].cmd, vecs[v].addr, vecs[v].has_addr, vecs[v].n, vecs[v].d, rx);
      if (vecs[v].chk)
        for (int k = 0; k < vecs[v].n; k++)
          check($sformatf("%s[%0d]", vecs[v].name, k), rx[k], vecs[v].d[k]);
    end

    // Unknown command, then 32 more sclk cycles: so must never go high.
    mon_en = 1'b1;
    xfer(8'h9F, 24'h0, 0, 4, {8'hFF,8'hFF,8'hFF,8'hFF}, rx);
    mon_en = 1'b0;
    for (int k = 0; k < 4; k++) check($sformatf("unk_byte[%0d]", k), rx[k], 8'h00);
    check("unk_so_hits", so_hits[7:0], 8'h00);
    xfer(CMD_READ, 24'h000010, 1, 1, '0, rx);
    check("after_unk_rd10", rx[0], 8'hA5);

    // Abort a write data byte after 5 bits.
    @(negedge clk);
    spi.sram_ce = 1'b0;
    #(HALF);
    spi_byte(CMD_WRITE, b);
    spi_byte(8'h00, b);
    spi_byte(8'h00, b);
    spi_byte(8'h20, b);
    for (int i = 0; i < 5; i++) begin
      spi.si = 1'b1; #(HALF); spi.sclk = 1'b1; #(HALF); spi.sclk = 1'b0;
    end
    #(HALF);
    spi.sram_ce = 1'b1;
    #(4*HALF);
    xfer(CMD_READ, 24'h000020, 1, 1, '0, rx);
    check("abort_rd20", rx[0], 8'h77);

    // Reset in the middle of a READ.
    @(negedge clk);
    spi.sram_ce = 1'b0;
    #(HALF);
    spi_byte(CMD_READ, b);
    spi_byte(8'h00, b);
    spi_byte(8'h00, b);
    spi_byte(8'h10, b);
    spi.si = 1'b0;
    #(HALF);
    spi.sclk = 1'b1;
    check("midrd_bit7", {7'b0, spi.so}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrd_so", {7'b0, spi.so}, 8'h00);
    check("midrd_state", {5'b0, dut.r_state}, {5'b0, IDLE});
    spi.sclk    = 1'b0;
    spi.sram_ce = 1'b1;
    #(2*HALF);
    reset = 1'b1;
    #(2*HALF);
    xfer(CMD_READ, 24'h000010, 1, 1, '0, rx);
    check("post_reset_rd10", rx[0], 8'hA5);

`ifdef SPI_SRAM_MODE_REG_EN
    xfer(CMD_WRMR, 24'h0, 0, 1, {8'h00,8'h00,8'h00,8'h00}, rx);
    xfer(CMD_READ, 24'h000010, 1, 2, '0, rx);
    check("byte_rd[0]", rx[0], 8'hA5);
    check("byte_rd[1]", rx[1], 8'h00);
    xfer(CMD_RDMR, 24'h0, 0, 1, '0, rx);
    check("rdmr_byte", rx[0], 8'h00);
    xfer(CMD_WRMR, 24'h0, 0, 1, {8'h80,8'h00,8'h00,8'h00}, rx);
    xfer(CMD_WRITE, 24'h00001E, 1, 3, {8'hB1,8'hB2,8'hB3,8'h00}, rx);
    xfer(CMD_READ, 24'h00001E, 1, 3, '0, rx);
    check("page_rd[0]", rx[0], 8'hB1);
    check("page_rd[1]", rx[1], 8'hB2);
    check("page_rd[2]", rx[2], 8'hB3);
    xfer(CMD_RDMR, 24'h0, 0, 1, '0, rx);
    check("rdmr_page", rx[0], 8'h80);
    xfer(CMD_READ, 24'h000020, 1, 1, '0, rx);
    check("page_keep20", rx[0], 8'h77);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
